// File: rtl/pc_sequencer_if.sv
// Decode/handshake inputs and control outputs shared between the PC sequencer
// and its surrounding datapath.
interface pc_sequencer_if;
  logic       is_j;
  logic       is_jr;
  logic       is_branch;
  logic       is_mem;
  logic       is_load;
  logic       is_eret;
  logic       branch_taken;
  logic       mem_ready;
  logic       int_req;
  logic       int_en;
  logic       PCWr;
  logic [2:0] NPCSel;
  logic       IRWr;
  logic       RegWr;
  logic       EPCWr;
  logic       exl;
  logic       bus_err;
  logic [2:0] state;

  modport slave (
    input  is_j, is_jr, is_branch, is_mem, is_load, is_eret,
    input  branch_taken, mem_ready, int_req, int_en,
    output PCWr, NPCSel, IRWr, RegWr, EPCWr, exl, bus_err, state
  );

  modport master (
    output is_j, is_jr, is_branch, is_mem, is_load, is_eret,
    output branch_taken, mem_ready, int_req, int_en,
    input  PCWr, NPCSel, IRWr, RegWr, EPCWr, exl, bus_err, state
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXEC/MEM/WB plus an interrupt
// entry state, with a bounded memory wait and a single-level exception flag.
module pc_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 8
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_INT    = 3'd5;

  localparam logic [2:0] NPC_SEQ = 3'd0;
  localparam logic [2:0] NPC_REG = 3'd1;
  localparam logic [2:0] NPC_JMP = 3'd2;
  localparam logic [2:0] NPC_BR  = 3'd3;
  localparam logic [2:0] NPC_VEC = 3'd4;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

  logic [2:0] state_q, state_d;
  logic       exl_q;
  logic [7:0] wait_q;

  logic       pc_wr, ir_wr, reg_wr, epc_wr, bus_err;
  logic [2:0] npc_sel;
  logic       set_exl, clr_exl, wait_clr, wait_inc;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d  = S_FETCH;
    pc_wr    = 1'b0;
    npc_sel  = NPC_SEQ;
    ir_wr    = 1'b0;
    reg_wr   = 1'b0;
    epc_wr   = 1'b0;
    bus_err  = 1'b0;
    set_exl  = 1'b0;
    clr_exl  = 1'b0;
    wait_clr = 1'b0;
    wait_inc = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (bus.int_req && bus.int_en && !exl_q) begin
          state_d = S_INT;
        end else begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (bus.is_j) begin
          pc_wr   = 1'b1;
          npc_sel = NPC_JMP;
        end else if (bus.is_jr) begin
          pc_wr   = 1'b1;
          npc_sel = NPC_REG;
        end else if (bus.is_eret) begin
          // The external NPC mux presents EPC on the register-jump input here.
          pc_wr   = 1'b1;
          npc_sel = NPC_REG;
          clr_exl = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (bus.is_branch) begin
          pc_wr   = bus.branch_taken;
          npc_sel = NPC_BR;
        end else if (bus.is_mem) begin
          wait_clr = 1'b1;
          state_d  = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (bus.mem_ready) begin
          state_d = bus.is_load ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          bus_err = 1'b1;
        end else begin
          wait_inc = 1'b1;
          state_d  = S_MEM;
        end
      end
      S_WB: begin
        reg_wr = 1'b1;
      end
      S_INT: begin
        epc_wr  = 1'b1;
        pc_wr   = 1'b1;
        npc_sel = NPC_VEC;
        set_exl = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
      exl_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignments so all flops update together.
      state_q <= state_d;
      if (set_exl)      exl_q <= 1'b1;
      else if (clr_exl) exl_q <= 1'b0;
      if (wait_clr)      wait_q <= '0;
      else if (wait_inc) wait_q <= wait_q + 8'd1;
    end
  end

  // Enables are held off while reset is low, so an aborted sequence emits nothing.
  assign bus.PCWr    = reset & pc_wr;
  assign bus.NPCSel  = reset ? npc_sel : NPC_SEQ;
  assign bus.IRWr    = reset & ir_wr;
  assign bus.RegWr   = reset & reg_wr;
  assign bus.EPCWr   = reset & epc_wr;
  assign bus.bus_err = reset & bus_err;
  assign bus.exl     = exl_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench: an instruction-level model expands each instruction into
// its expected per-cycle state/enable trace, compared against the sequencer.
module tb_pc_sequencer;
  localparam int MAXW = 8;

  localparam logic [2:0] F = 3'd0, D = 3'd1, E = 3'd2, M = 3'd3, W = 3'd4, I = 3'd5;

  typedef enum int {C_ALU, C_J, C_JR, C_BR, C_LOAD, C_STORE, C_ERET} cls_t;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr;
    logic [2:0] npc;
    logic       irwr;
    logic       regwr;
    logic       epcwr;
    logic       berr;
    logic       exl;
  } obs_t;

  typedef struct {
    obs_t o;
    bit   mrdy;
  } step_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  pc_sequencer_if bus_if ();

  pc_sequencer #(.MEM_WAIT_MAX(MAXW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if.slave)
  );

  always #5 clk = ~clk;

  int    vectors = 0;
  int    miscompares = 0;
  bit    m_exl = 1'b0;
  step_t inst_q[$];
  obs_t  exp_q[$];
  obs_t  got_q[$];

  function automatic obs_t observe();
    obs_t o;
    o.st    = bus_if.state;
    o.pcwr  = bus_if.PCWr;
    o.npc   = bus_if.NPCSel;
    o.irwr  = bus_if.IRWr;
    o.regwr = bus_if.RegWr;
    o.epcwr = bus_if.EPCWr;
    o.berr  = bus_if.bus_err;
    o.exl   = bus_if.exl;
    return o;
  endfunction

  function automatic obs_t mk(input logic [2:0] st, input logic pcwr, input logic [2:0] npc,
                              input logic irwr, input logic regwr, input logic epcwr,
                              input logic berr);
    obs_t o;
    o.st = st; o.pcwr = pcwr; o.npc = npc; o.irwr = irwr;
    o.regwr = regwr; o.epcwr = epcwr; o.berr = berr; o.exl = 1'b0;
    return o;
  endfunction

  task automatic push(input obs_t o, input bit mrdy);
    step_t s;
    o.exl  = m_exl;
    s.o    = o;
    s.mrdy = mrdy;
    inst_q.push_back(s);
  endtask

  // Instruction-level model: interrupt entry, then fetch, then the class-specific tail.
  // ready_at = k means mem_ready is presented on the k-th MEM cycle (0 = never).
  task automatic expand(input cls_t c, input bit taken, input int ready_at,
                        input bit irq, input bit ien);
    inst_q.delete();
    if (irq && ien && !m_exl) begin
      push(mk(F, 0, 3'd0, 0, 0, 0, 0), 0);
      push(mk(I, 1, 3'd4, 0, 0, 1, 0), 0);
      m_exl = 1'b1;
    end
    push(mk(F, 1, 3'd0, 1, 0, 0, 0), 0);
    if (c == C_J) begin
      push(mk(D, 1, 3'd2, 0, 0, 0, 0), 0);
    end else if (c == C_JR) begin
      push(mk(D, 1, 3'd1, 0, 0, 0, 0), 0);
    end else if (c == C_ERET) begin
      push(mk(D, 1, 3'd1, 0, 0, 0, 0), 0);
      m_exl = 1'b0;
    end else begin
      push(mk(D, 0, 3'd0, 0, 0, 0, 0), 0);
      if (c == C_BR) begin
        push(mk(E, taken, 3'd3, 0, 0, 0, 0), 0);
      end else if (c == C_ALU) begin
        push(mk(E, 0, 3'd0, 0, 0, 0, 0), 0);
        push(mk(W, 0, 3'd0, 0, 1, 0, 0), 0);
      end else begin
        push(mk(E, 0, 3'd0, 0, 0, 0, 0), 0);
        for (int k = 1; k <= MAXW; k++) begin
          if (k == ready_at) begin
            push(mk(M, 0, 3'd0, 0, 0, 0, 0), 1);
            if (c == C_LOAD) push(mk(W, 0, 3'd0, 0, 1, 0, 0), 0);
            break;
          end else if (k == MAXW) begin
            push(mk(M, 0, 3'd0, 0, 0, 0, 1), 0);
          end else begin
            push(mk(M, 0, 3'd0, 0, 0, 0, 0), 0);
          end
        end
      end
    end
  endtask

  // Drives one instruction cycle by cycle; abort_at >= 0 pulls reset low mid-cycle there.
  task automatic run_instr(input cls_t c, input bit taken, input int ready_at, input bit irq,
                           input bit ien, input bit load_noise, input int abort_at);
    expand(c, taken, ready_at, irq, ien);
    foreach (inst_q[i]) begin
      @(negedge clk);
      if (i == 0) begin
        bus_if.is_j         = (c == C_J);
        bus_if.is_jr        = (c == C_JR);
        bus_if.is_branch    = (c == C_BR);
        bus_if.is_mem       = (c == C_LOAD) || (c == C_STORE);
        bus_if.is_load      = (c == C_LOAD) || (load_noise && c != C_STORE);
        bus_if.is_eret      = (c == C_ERET);
        bus_if.branch_taken = taken;
        bus_if.int_req      = irq;
        bus_if.int_en       = ien;
      end
      bus_if.mem_ready = inst_q[i].mrdy;
      #1;
      got_q.push_back(observe());
      exp_q.push_back(inst_q[i].o);
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1;
        got_q.push_back(observe());
        exp_q.push_back(mk(F, 0, 3'd0, 0, 0, 0, 0));
        m_exl = 1'b0;
        @(posedge clk);
        #2 reset = 1'b1;
        break;
      end
    end
  endtask

  task automatic start_test();
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    obs_t zero;
    zero = mk(F, 0, 3'd0, 0, 0, 0, 0);
    #1;
    vectors++;
    if (observe() !== zero) begin
      miscompares++;
      $display("FAIL reset_initial: got %b, expected %b", observe(), zero);
    end
    repeat (2) @(posedge clk);
    #2;
    vectors++;
    if (observe() !== zero) begin
      miscompares++;
      $display("FAIL reset_held: got %b, expected %b", observe(), zero);
    end
    reset = 1'b1;
  endtask

  task automatic test_alu();
    start_test();
    run_instr(C_ALU, 0, 0, 0, 0, 0, -1);
    run_instr(C_ALU, 1, 0, 0, 0, 1, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL alu step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_branch_jump();
    start_test();
    run_instr(C_BR, 1, 0, 0, 0, 0, -1);
    run_instr(C_BR, 0, 0, 0, 0, 0, -1);
    run_instr(C_J,  0, 0, 0, 0, 0, -1);
    run_instr(C_JR, 0, 0, 0, 0, 0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL branch_jump step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_mem();
    start_test();
    run_instr(C_LOAD,  0, 3,    0, 0, 0, -1);
    run_instr(C_LOAD,  0, 1,    0, 0, 0, -1);
    run_instr(C_STORE, 0, 2,    0, 0, 0, -1);
    run_instr(C_STORE, 0, 0,    0, 0, 0, -1);
    run_instr(C_LOAD,  0, 0,    0, 0, 0, -1);
    run_instr(C_STORE, 0, MAXW, 0, 0, 0, -1);
    run_instr(C_LOAD,  0, MAXW, 0, 0, 0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL mem_wait step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_interrupt();
    start_test();
    run_instr(C_ALU,  0, 0, 1, 0, 0, -1);
    run_instr(C_ALU,  0, 0, 1, 1, 0, -1);
    run_instr(C_ALU,  0, 0, 1, 1, 0, -1);
    run_instr(C_ERET, 0, 0, 1, 1, 0, -1);
    run_instr(C_J,    0, 0, 1, 1, 0, -1);
    run_instr(C_ERET, 0, 0, 0, 1, 0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL interrupt step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    start_test();
    run_instr(C_ALU,   0, 0, 1, 1, 0, -1);
    run_instr(C_STORE, 0, 0, 0, 0, 0, 4);
    run_instr(C_ALU,   0, 0, 1, 1, 0, 1);
    run_instr(C_ALU,   0, 0, 0, 0, 0, -1);
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL async_reset step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    start_test();
    for (int n = 0; n < 60; n++) begin
      run_instr(cls_t'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, MAXW + 1)), ($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
    end
    foreach (exp_q[i]) begin
      vectors++;
      if (got_q[i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL back_to_back step %0d: got %b, expected %b", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus_if.is_j = 0; bus_if.is_jr = 0; bus_if.is_branch = 0; bus_if.is_mem = 0;
    bus_if.is_load = 0; bus_if.is_eret = 0; bus_if.branch_taken = 0;
    bus_if.mem_ready = 0; bus_if.int_req = 0; bus_if.int_en = 0;
    @(posedge clk);
    test_reset();
    test_alu();
    test_branch_jump();
    test_mem();
    test_interrupt();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter MEM_WAIT_MAX, default 8: maximum MEM-state wait cycles before timeout (range 1..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; low forces the reset state immediately.
REQ-004 is_j, is_jr, is_branch, is_mem, is_load, is_eret  input  1 each  decoded instruction class of the held instruction; at most one of is_j/is_jr/is_branch/is_mem/is_eret is high.
REQ-005 branch_taken  input  1  branch compare result; valid in EXEC.
REQ-006 mem_ready  input  1  data-memory completion strobe.
REQ-007 int_req  input  1  level-sensitive external interrupt request.
REQ-008 int_en  input  1  global interrupt enable.
REQ-009 PCWr  output  1  PC write enable to the fetch unit.
REQ-010 NPCSel  output  3  next-PC select: 0 PC+4, 1 register jump, 2 J jump, 3 branch, 4 interrupt vector.
REQ-011 IRWr, RegWr, EPCWr  output  1 each  instruction-register, register-file and EPC write enables.
REQ-012 exl  output  1  exception-level flag; high while inside a handler.
REQ-013 bus_err  output  1  one-cycle pulse on MEM timeout.
REQ-014 state  output  3  current FSM state code, for debug.

Function
REQ-015 States and codes: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, INT=5; codes 6 and 7 SHALL transition to FETCH with all enables low.
REQ-016 All enables SHALL be combinational from state and inputs; each enable defaults to 0 and NPCSel defaults to 0 unless a requirement below drives them.
REQ-017 FETCH, when int_req & int_en & !exl: no enables asserted; next state INT.
REQ-018 FETCH, otherwise: IRWr=1, PCWr=1, NPCSel=0; next state DECODE.
REQ-019 INT: EPCWr=1, PCWr=1, NPCSel=4; exl set to 1 at the clock edge; next state FETCH.
REQ-020 DECODE, is_j: PCWr=1, NPCSel=2; next state FETCH.
REQ-021 DECODE, is_jr: PCWr=1, NPCSel=1; next state FETCH.
REQ-022 DECODE, is_eret: PCWr=1, NPCSel=1 (the external mux presents EPC); exl cleared at the clock edge; next state FETCH.
REQ-023 DECODE, none of the above: next state EXEC.
REQ-024 EXEC, is_branch: PCWr=branch_taken, NPCSel=3; next state FETCH.
REQ-025 EXEC, is_mem: next state MEM, with the wait counter cleared to 0.
REQ-026 EXEC, otherwise: next state WB.
REQ-027 MEM, mem_ready=1: next state WB if is_load, else FETCH.
REQ-028 MEM, mem_ready=0: the 8-bit wait counter increments.
REQ-029 MEM timeout: when the counter equals MEM_WAIT_MAX-1 and mem_ready=0, bus_err pulses for one cycle and the next state is FETCH.
REQ-030 mem_ready=1 on the timeout cycle SHALL take priority over the timeout, with no bus_err.
REQ-031 WB: RegWr=1; next state FETCH.
REQ-032 Interrupts are sampled only in FETCH, so an instruction in flight always completes.
REQ-033 int_req is ignored while exl=1 (no nesting).
REQ-034 Latency per instruction class: J/JR/ERET 2 cycles; branch 3; ALU 4; store 3+wait; load 4+wait.
REQ-035 If is_eret and int_req arrive together, the eret completes first; the interrupt is taken in the following FETCH if int_req is still high.

Reset
REQ-036 reset low SHALL force the following immediately, without waiting for clk: state=FETCH, exl=0, wait counter=0, bus_err=0.
REQ-037 Releasing reset SHALL cause the first rising edge to perform a FETCH.
REQ-038 Reset asserted mid-MEM or mid-INT SHALL abort the sequence with no further enable pulses.

Verification
REQ-039 Reset release, ALU instruction (no class inputs high) -> states 0,1,2,4,0; IRWr and PCWr with NPCSel=0 in cycle 1; RegWr in cycle 4.
REQ-040 Branch with branch_taken=1, then with branch_taken=0 -> EXEC shows NPCSel=3 with PCWr=1, then PCWr=0; both return to FETCH.
REQ-041 Load with mem_ready high on the 3rd MEM cycle, MEM_WAIT_MAX=8 -> 3 MEM cycles, then WB with RegWr=1, bus_err never high.
REQ-042 Store with mem_ready never high, MEM_WAIT_MAX=8 -> exactly 8 MEM cycles, bus_err high for 1 cycle, then FETCH.
REQ-043 int_req=1 and int_en=1 in FETCH -> INT with EPCWr=1, PCWr=1, NPCSel=4; exl=1 afterwards; a second int_req is ignored until an eret in DECODE clears exl.
REQ-044 reset pulled low asynchronously during MEM -> state=0 and exl=0 before the next clk edge; all enables low.
